// File: rtl/multicycle_ctrl_if.sv
// Unified-memory request/ready handshake between the multicycle controller
// (master) and the memory port (slave).
interface multicycle_ctrl_if;
    logic mem_read;
    logic mem_write;
    logic i_or_d;
    logic mem_ready;

    modport master (output mem_read, output mem_write, output i_or_d, input mem_ready);
    modport slave  (input mem_read, input mem_write, input i_or_d, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: IF -> ID -> EX -> MEM -> WB with memory timeout.
// Optional `MC_CTRL_PERF_EN adds retired-instruction and cycle counters.
module multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 255
) (
    input  logic                     clk,
    input  logic                     reset_n,
    multicycle_ctrl_if.master        mem,
    input  logic [6:0]               ir_opcode,
    input  logic [2:0]               ir_funct3,
    input  logic [6:0]               ir_funct7,
    input  logic                     bcond,
    input  logic                     halt_req,
    output logic                     ir_write,
    output logic                     pc_write,
    output logic [1:0]               pc_source,
    output logic [1:0]               alu_src_a,
    output logic                     alu_src_b,
    output logic [6:0]               alu_opcode,
    output logic [2:0]               alu_funct3,
    output logic [6:0]               alu_funct7,
    output logic                     reg_write,
    output logic [1:0]               wb_sel,
    output logic                     halted,
`ifdef MC_CTRL_PERF_EN
    output logic [31:0]              retired_cnt,
    output logic [31:0]              cycle_cnt,
`endif
    output logic                     mem_err
);

    typedef enum logic [2:0] {
        S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] PC_PLUS4 = 2'b00, PC_ALUOUT = 2'b01, PC_ALURES = 2'b10;
    localparam logic [1:0] A_PC = 2'b00, A_REG = 2'b01, A_ZERO = 2'b10;
    localparam logic [1:0] WB_ALU = 2'b00, WB_MDR = 2'b01, WB_PC4 = 2'b10;
    localparam logic [15:0] WAIT_MAX = 16'(MEM_WAIT_MAX);

    state_t      state, state_next;
    logic [6:0]  op_q;
    logic [15:0] wait_cnt;
    logic        alu_pass;
    logic        timeout;

    assign halted = (state == S_HALT);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_next    = state;
        mem.mem_read  = 1'b0;
        mem.mem_write = 1'b0;
        mem.i_or_d    = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_source     = PC_PLUS4;
        alu_src_a     = A_PC;
        alu_src_b     = 1'b0;
        reg_write     = 1'b0;
        wb_sel        = WB_ALU;
        alu_pass      = 1'b0;
        timeout       = 1'b0;

        unique case (state)
            S_IF: begin
                mem.mem_read = 1'b1;
                ir_write     = mem.mem_ready;
                if (mem.mem_ready) begin
                    state_next = S_ID;
                end else if (wait_cnt == WAIT_MAX) begin
                    timeout    = 1'b1;
                    state_next = S_HALT;
                end
            end
            S_ID: begin
                alu_src_a = A_PC;
                alu_src_b = 1'b1;
                unique case (ir_opcode)
                    OP_SYSTEM: begin
                        if (halt_req) begin
                            state_next = S_HALT;
                        end else begin
                            pc_write   = 1'b1;
                            state_next = S_IF;
                        end
                    end
                    OP_R, OP_I, OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC,
                    OP_BRANCH, OP_JAL, OP_JALR: state_next = S_EX;
                    default: begin
                        pc_write   = 1'b1;
                        state_next = S_IF;
                    end
                endcase
            end
            S_EX: begin
                // Decode from the opcode captured in ID; the IR may already hold the next word.
                unique case (op_q)
                    OP_R: begin
                        alu_src_a = A_REG;
                        alu_pass = 1'b1;
                        state_next = S_WB;
                    end
                    OP_I: begin
                        alu_src_a = A_REG;
                        alu_src_b = 1'b1;
                        alu_pass = 1'b1;
                        state_next = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a = A_REG;
                        alu_src_b = 1'b1;
                        state_next = S_MEM;
                    end
                    OP_LUI: begin
                        alu_src_a = A_ZERO;
                        alu_src_b = 1'b1;
                        state_next = S_WB;
                    end
                    OP_AUIPC: begin
                        alu_src_a = A_PC;
                        alu_src_b = 1'b1;
                        state_next = S_WB;
                    end
                    OP_BRANCH: begin
                        alu_src_a = A_REG;
                        alu_pass = 1'b1;
                        pc_write = 1'b1;
                        pc_source = bcond ? PC_ALUOUT : PC_PLUS4;
                        state_next = S_IF;
                    end
                    OP_JAL: begin
                        reg_write = 1'b1;
                        wb_sel = WB_PC4;
                        pc_write = 1'b1;
                        pc_source = PC_ALUOUT;
                        state_next = S_IF;
                    end
                    OP_JALR: begin
                        alu_src_a = A_REG;
                        alu_src_b = 1'b1;
                        reg_write = 1'b1;
                        wb_sel = WB_PC4;
                        pc_write = 1'b1;
                        pc_source = PC_ALURES;
                        state_next = S_IF;
                    end
                    default: begin
                        pc_write = 1'b1;
                        state_next = S_IF;
                    end
                endcase
            end
            S_MEM: begin
                mem.i_or_d    = 1'b1;
                mem.mem_read  = (op_q == OP_LOAD);
                mem.mem_write = (op_q != OP_LOAD);
                if (mem.mem_ready) begin
                    if (op_q == OP_LOAD) begin
                        state_next = S_WB;
                    end else begin
                        pc_write   = 1'b1;
                        state_next = S_IF;
                    end
                end else if (wait_cnt == WAIT_MAX) begin
                    timeout    = 1'b1;
                    state_next = S_HALT;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                wb_sel     = (op_q == OP_LOAD) ? WB_MDR : WB_ALU;
                pc_write   = 1'b1;
                state_next = S_IF;
            end
            default: state_next = S_HALT;
        endcase

        if (alu_pass) begin
            alu_opcode = ir_opcode;
            alu_funct3 = ir_funct3;
            alu_funct7 = ir_funct7;
        end else begin
            alu_opcode = OP_R;
            alu_funct3 = 3'b000;
            alu_funct7 = 7'b0000000;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IF;
            op_q     <= '0;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
`ifdef MC_CTRL_PERF_EN
            retired_cnt <= '0;
            cycle_cnt   <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // register samples pre-edge values regardless of statement order.
            state <= state_next;
            if (state == S_ID) op_q <= ir_opcode;
            if (timeout) mem_err <= 1'b1;
            if (state_next != state && (state_next == S_IF || state_next == S_MEM))
                wait_cnt <= '0;
            else if ((state == S_IF || state == S_MEM) && !mem.mem_ready && wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + 16'd1;
`ifdef MC_CTRL_PERF_EN
            if (state != S_HALT) cycle_cnt <= cycle_cnt + 32'd1;
            if (state_next == S_IF && state != S_IF) retired_cnt <= retired_cnt + 32'd1;
`endif
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (MEM_WAIT_MAX = 4).
// Memory ready is modelled per request with a programmable wait count.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [6:0]  ir_opcode = '0;
    logic [2:0]  ir_funct3 = '0;
    logic [6:0]  ir_funct7 = '0;
    logic        bcond = 1'b0;
    logic        halt_req = 1'b0;
    logic        ir_write, pc_write, alu_src_b, reg_write, halted, mem_err;
    logic [1:0]  pc_source, alu_src_a, wb_sel;
    logic [6:0]  alu_opcode, alu_funct7;
    logic [2:0]  alu_funct3;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] retired_cnt, cycle_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [39:0] r_regw, r_pcw, r_mr, r_mw, r_iod, r_sb;
    logic [1:0]  r_pcsrc [40];
    logic [1:0]  r_sa [40];
    logic [1:0]  r_wb [40];
    logic [6:0]  r_op [40];
    logic [6:0]  r_f7 [40];
    logic [2:0]  r_f3 [40];
    int          n;

    multicycle_ctrl_if mif ();

    multicycle_ctrl #(.MEM_WAIT_MAX(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mem        (mif),
        .ir_opcode  (ir_opcode),
        .ir_funct3  (ir_funct3),
        .ir_funct7  (ir_funct7),
        .bcond      (bcond),
        .halt_req   (halt_req),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_source  (pc_source),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_opcode (alu_opcode),
        .alu_funct3 (alu_funct3),
        .alu_funct7 (alu_funct7),
        .reg_write  (reg_write),
        .wb_sel     (wb_sel),
        .halted     (halted),
`ifdef MC_CTRL_PERF_EN
        .retired_cnt(retired_cnt),
        .cycle_cnt  (cycle_cnt),
`endif
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        ir_opcode = op;
        ir_funct3 = f3;
        ir_funct7 = f7;
    endtask

    // Runs one instruction from IF, called at posedge+1. Ready is withheld for
    // if_wait / mem_wait request cycles. Stops after the PC-writing cycle or on HALT.
    task automatic run_instr(input int if_wait, input int mem_wait, input bit late_en,
                             input logic [6:0] late_op, output int cycles);
        int req;
        req = 0;
        cycles = 0;
        r_regw = '0; r_pcw = '0; r_mr = '0; r_mw = '0; r_iod = '0; r_sb = '0;
        for (int i = 0; i < 40; i++) begin
            if (late_en && i == 2) ir_opcode = late_op;
            mif.mem_ready = 1'b0;
            #1;
            if (mif.mem_read || mif.mem_write) begin
                mif.mem_ready = (req >= (mif.i_or_d ? mem_wait : if_wait));
                req = mif.mem_ready ? 0 : req + 1;
            end
            #1;
            r_regw[i] = reg_write;   r_pcw[i] = pc_write;     r_mr[i] = mif.mem_read;
            r_mw[i] = mif.mem_write; r_iod[i] = mif.i_or_d;   r_sb[i] = alu_src_b;
            r_pcsrc[i] = pc_source;  r_sa[i] = alu_src_a;     r_wb[i] = wb_sel;
            r_op[i] = alu_opcode;    r_f7[i] = alu_funct7;    r_f3[i] = alu_funct3;
            cycles = i + 1;
            @(posedge clk);
            #1;
            mif.mem_ready = 1'b0;
            if (r_pcw[i] || halted) break;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 reset_n = 1'b0;
        mif.mem_ready = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        mif.mem_ready = 1'b0;
        #3;
        check("rst_mem_read", 32'(mif.mem_read), 1);
        check("rst_mem_write", 32'(mif.mem_write), 0);
        check("rst_ir_write", 32'(ir_write), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_mem_err", 32'(mem_err), 0);
        check("rst_reg_write", 32'(reg_write), 0);
        mif.mem_ready = 1'b1;
        #1;
        check("rst_ir_write_ready", 32'(ir_write), 1);
        mif.mem_ready = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;

        // add-class R-type with a non-zero funct7 (sub) to see pass-through
        set_ir(7'b0110011, 3'b000, 7'b0100000);
        run_instr(0, 0, 1'b0, 7'h0, n);
        check("add_cycles", n, 4);
        check("add_regw_mask", r_regw[31:0], 32'b1000);
        check("add_id_forced_f7", 32'(r_f7[1]), 0);
        check("add_ex_opcode", 32'(r_op[2]), 32'h33);
        check("add_ex_f7", 32'(r_f7[2]), 32'h20);
        check("add_ex_src_a", 32'(r_sa[2]), 1);
        check("add_ex_src_b", 32'(r_sb[2]), 0);
        check("add_wb_sel", 32'(r_wb[3]), 0);
        check("add_pc_source", 32'(r_pcsrc[3]), 0);

        set_ir(7'b1100011, 3'b000, 7'b0000000);
        bcond = 1'b1;
        run_instr(0, 0, 1'b0, 7'h0, n);
        check("beq_t_cycles", n, 3);
        check("beq_t_pc_source", 32'(r_pcsrc[2]), 1);
        check("beq_t_regw_mask", r_regw[31:0], 0);
        bcond = 1'b0;
        run_instr(0, 0, 1'b0, 7'h0, n);
        check("beq_nt_cycles", n, 3);
        check("beq_nt_pc_source", 32'(r_pcsrc[2]), 0);
        check("beq_nt_pc_write", 32'(r_pcw[2]), 1);
        check("beq_nt_regw_mask", r_regw[31:0], 0);

        set_ir(7'b0000011, 3'b010, 7'b0000000);
        run_instr(0, 3, 1'b0, 7'h0, n);
        check("lw_cycles", n, 8);
        check("lw_mem_rd_mask", (r_mr[31:0] & r_iod[31:0]), 32'b0111_1000);
        check("lw_ex_forced_f3", 32'(r_f3[2]), 0);
        check("lw_wb_sel", 32'(r_wb[7]), 1);
        check("lw_regw_mask", r_regw[31:0], 32'b1000_0000);

        set_ir(7'b0100011, 3'b010, 7'b0000000);
        run_instr(0, 0, 1'b0, 7'h0, n);
        check("sw_cycles", n, 4);
        check("sw_mem_wr_mask", (r_mw[31:0] & r_iod[31:0]), 32'b1000);
        check("sw_regw_mask", r_regw[31:0], 0);

        set_ir(7'b1101111, 3'b000, 7'b0000000);
        run_instr(0, 0, 1'b0, 7'h0, n);
        check("jal_cycles", n, 3);
        check("jal_wb_sel", 32'(r_wb[2]), 2);
        check("jal_pc_source", 32'(r_pcsrc[2]), 1);
        check("jal_regw_mask", r_regw[31:0], 32'b100);

        set_ir(7'b1100111, 3'b000, 7'b0000000);
        run_instr(0, 0, 1'b0, 7'h0, n);
        check("jalr_cycles", n, 3);
        check("jalr_pc_source", 32'(r_pcsrc[2]), 2);
        check("jalr_src_a", 32'(r_sa[2]), 1);
        check("jalr_src_b", 32'(r_sb[2]), 1);

        set_ir(7'b0110111, 3'b000, 7'b0000000);
        run_instr(0, 0, 1'b0, 7'h0, n);
        check("lui_cycles", n, 4);
        check("lui_src_a", 32'(r_sa[2]), 2);

        set_ir(7'b0001111, 3'b000, 7'b0000000);
        run_instr(0, 0, 1'b0, 7'h0, n);
        check("nop_cycles", n, 2);
        check("nop_pc_write", 32'(r_pcw[1]), 1);

        set_ir(7'b1110011, 3'b000, 7'b0000000);
        halt_req = 1'b0;
        run_instr(0, 0, 1'b0, 7'h0, n);
        check("ecall_nop_cycles", n, 2);
        check("ecall_nop_halted", 32'(halted), 0);

        // IR rewritten to a branch after ID must not change the addi flow
        set_ir(7'b0010011, 3'b000, 7'b0000000);
        run_instr(0, 0, 1'b1, 7'b1100011, n);
        check("late_ir_cycles", n, 4);
        check("late_ir_regw_mask", r_regw[31:0], 32'b1000);

        // Ready on the cycle the wait count reaches the limit completes normally
        set_ir(7'b0110011, 3'b000, 7'b0000000);
        run_instr(4, 0, 1'b0, 7'h0, n);
        check("edge_wait_cycles", n, 8);
        check("edge_wait_mem_err", 32'(mem_err), 0);

        run_instr(100, 0, 1'b0, 7'h0, n);
        check("timeout_cycles", n, 5);
        check("timeout_mem_err", 32'(mem_err), 1);
        check("timeout_halted", 32'(halted), 1);
        check("timeout_mem_read", 32'(mif.mem_read), 0);
        @(posedge clk);
        #1;
        check("timeout_strobes", 32'({mif.mem_write, ir_write, pc_write, reg_write}), 0);

        do_reset();
        check("reset_clears_err", 32'(mem_err), 0);
        set_ir(7'b1110011, 3'b000, 7'b0000000);
        halt_req = 1'b1;
        run_instr(0, 0, 1'b0, 7'h0, n);
        check("ecall_halt_cycles", n, 2);
        repeat (2) @(posedge clk);
        #1;
        check("halt_held", 32'(halted), 1);
        check("halt_no_read", 32'(mif.mem_read), 0);
        #3 reset_n = 1'b0;
        #1;
        check("async_rst_mem_read", 32'(mif.mem_read), 1);
        check("async_rst_halted", 32'(halted), 0);
        halt_req = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;

`ifdef MC_CTRL_PERF_EN
        set_ir(7'b0010011, 3'b000, 7'b0000000);
        for (int k = 0; k < 10; k++) run_instr(0, 0, 1'b0, 7'h0, n);
        check("perf_retired", retired_cnt, 10);
        check("perf_cycles", cycle_cnt, 40);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
